// File: rtl/fetch_decode.sv
// Single-issue fetch unit with RV32I decode.
// One outstanding memory fetch; decoded fields are held between issues.
module fetch_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        iq_full,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   output logic [4:0]  op,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        has_imm,
   output logic [31:0] pc_out,
   output logic        illegal
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE, S_DRAIN} state_t;
   localparam logic [4:0] OP_NONE = 5'b11111;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, word_q, word_d, imm_q, imm_d, pc_out_q, pc_out_d;
   logic [4:0]  op_q, op_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic        mem_req_q, mem_req_d, has_imm_q, has_imm_d;
   logic        illegal_q, illegal_d;

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic [4:0]  dec_op, dec_rs1, dec_rs2, dec_rd;
   logic [31:0] dec_imm;
   logic        dec_has_imm, dec_ok;

   assign opc    = word_q[6:0];
   assign f3     = word_q[14:12];
   assign f7     = word_q[31:25];
   assign imm_i  = {{20{word_q[31]}}, word_q[31:20]};
   assign imm_s  = {{20{word_q[31]}}, word_q[31:25], word_q[11:7]};
   assign imm_b  = {{20{word_q[31]}}, word_q[7], word_q[30:25],
                    word_q[11:8], 1'b0};
   assign imm_u  = {word_q[31:12], 12'b0};
   assign imm_j  = {{12{word_q[31]}}, word_q[19:12], word_q[20],
                    word_q[30:21], 1'b0};
   assign imm_sh = {27'b0, word_q[24:20]};

   always_comb begin
      dec_ok      = 1'b1;
      dec_op      = OP_NONE;
      dec_rs1     = word_q[19:15];
      dec_rs2     = word_q[24:20];
      dec_rd      = word_q[11:7];
      dec_imm     = 32'b0;
      dec_has_imm = 1'b1;
      unique case (1'b1)
         opc == 7'b0110111, opc == 7'b0010111: begin
            dec_op  = (opc[5]) ? 5'd0 : 5'd1;
            dec_rs1 = 5'd0;
            dec_rs2 = 5'd0;
            dec_imm = imm_u;
         end
         opc == 7'b1101111: begin
            dec_op  = 5'd2;
            dec_rs1 = 5'd0;
            dec_rs2 = 5'd0;
            dec_imm = imm_j;
         end
         opc == 7'b1100111: begin
            dec_op  = 5'd3;
            dec_rs2 = 5'd0;
            dec_imm = imm_i;
            dec_ok  = (f3 == 3'd0);
         end
         opc == 7'b1100011: begin
            dec_rd  = 5'd0;
            dec_imm = imm_b;
            case (f3)
               3'd0:    dec_op = 5'd4;
               3'd1:    dec_op = 5'd5;
               3'd4:    dec_op = 5'd6;
               3'd5:    dec_op = 5'd7;
               3'd6:    dec_op = 5'd8;
               3'd7:    dec_op = 5'd9;
               default: dec_ok = 1'b0;
            endcase
         end
         opc == 7'b0000011: begin
            dec_rs2 = 5'd0;
            dec_imm = imm_i;
            case (f3)
               3'd0:    dec_op = 5'd10;
               3'd1:    dec_op = 5'd11;
               3'd2:    dec_op = 5'd12;
               3'd4:    dec_op = 5'd13;
               3'd5:    dec_op = 5'd14;
               default: dec_ok = 1'b0;
            endcase
         end
         opc == 7'b0100011: begin
            dec_rd  = 5'd0;
            dec_imm = imm_s;
            case (f3)
               3'd0:    dec_op = 5'd15;
               3'd1:    dec_op = 5'd16;
               3'd2:    dec_op = 5'd17;
               default: dec_ok = 1'b0;
            endcase
         end
         opc == 7'b0010011: begin
            dec_rs2 = 5'd0;
            dec_imm = imm_i;
            case (f3)
               3'd0: dec_op = 5'd18;
               3'd1: begin
                  dec_op  = 5'd20;
                  dec_imm = imm_sh;
                  dec_ok  = (f7 == 7'h00);
               end
               3'd2: dec_op = 5'd21;
               3'd3: dec_op = 5'd22;
               3'd4: dec_op = 5'd23;
               3'd5: begin
                  dec_op  = f7[5] ? 5'd25 : 5'd24;
                  dec_imm = imm_sh;
                  dec_ok  = (f7 == 7'h00) || (f7 == 7'h20);
               end
               3'd6: dec_op = 5'd26;
               default: dec_op = 5'd27;
            endcase
         end
         opc == 7'b0110011: begin
            dec_has_imm = 1'b0;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: dec_op = 5'd18;
                  3'd1: dec_op = 5'd20;
                  3'd2: dec_op = 5'd21;
                  3'd3: dec_op = 5'd22;
                  3'd4: dec_op = 5'd23;
                  3'd5: dec_op = 5'd24;
                  3'd6: dec_op = 5'd26;
                  default: dec_op = 5'd27;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
               dec_op = 5'd19;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               dec_op = 5'd25;
            end else begin
               dec_ok = 1'b0;
            end
         end
         default: dec_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      word_d    = word_q;
      op_d      = OP_NONE;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      has_imm_d = has_imm_q;
      pc_out_d  = pc_out_q;
      illegal_d = illegal_q;
      unique case (state_q)
         S_REQ: begin
            if (redirect) begin
               pc_d   = redirect_pc;
               word_d = 32'b0;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               word_d  = 32'b0;
               state_d = mem_ready ? S_REQ : S_DRAIN;
            end else if (mem_ready) begin
               word_d  = mem_data;
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (redirect) pc_d = redirect_pc;
            if (mem_ready) state_d = S_REQ;
         end
         S_ISSUE: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               word_d  = 32'b0;
               state_d = S_REQ;
            end else if (!iq_full) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
               if (dec_ok) begin
                  op_d      = dec_op;
                  rs1_d     = dec_rs1;
                  rs2_d     = dec_rs2;
                  rd_d      = dec_rd;
                  imm_d     = dec_imm;
                  has_imm_d = dec_has_imm;
                  pc_out_d  = pc_q;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
      endcase
      // request line follows the state it is entering, so it is glitch-free
      mem_req_d = (state_d == S_REQ) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_REQ;
         pc_q      <= 32'b0;
         word_q    <= 32'b0;
         mem_req_q <= 1'b0;
         op_q      <= OP_NONE;
         rs1_q     <= 5'b0;
         rs2_q     <= 5'b0;
         rd_q      <= 5'b0;
         imm_q     <= 32'b0;
         has_imm_q <= 1'b0;
         pc_out_q  <= 32'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         word_q    <= word_d;
         mem_req_q <= mem_req_d;
         op_q      <= op_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         has_imm_q <= has_imm_d;
         pc_out_q  <= pc_out_d;
         illegal_q <= illegal_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign op       = op_q;
   assign rs1      = rs1_q;
   assign rs2      = rs2_q;
   assign rd       = rd_q;
   assign imm      = imm_q;
   assign has_imm  = has_imm_q;
   assign pc_out   = pc_out_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode.
// Hand-computed expected values for each vector.
module tb_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iq_full = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_data = 32'b0;
   logic [4:0]  op, rs1, rs2, rd;
   logic [31:0] imm, pc_out;
   logic        has_imm, illegal;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [31:0] BUB = 32'h1F;

   fetch_decode dut (
      .clk(clk), .rst(rst), .iq_full(iq_full),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_data(mem_data),
      .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm(imm), .has_imm(has_imm), .pc_out(pc_out),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // from REQ: go to WAIT, return w at once, then let it issue
   task automatic serve(input logic [31:0] w);
      step();
      mem_ready = 1'b1;
      mem_data  = w;
      step();
      mem_ready = 1'b0;
      step();
   endtask

   initial begin
      step();
      step();
      check("rst_op", op, BUB);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_pcout", pc_out, 0);
      check("rst_ill", illegal, 0);
      rst = 1'b1;

      step();
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 0);
      mem_ready = 1'b1;
      mem_data  = 32'h00500093;
      step();
      mem_ready = 1'b0;
      check("wait_bub", op, BUB);
      check("wait_req", mem_req, 0);
      step();
      check("addi_op", op, 18);
      check("addi_rd", rd, 1);
      check("addi_rs1", rs1, 0);
      check("addi_imm", imm, 5);
      check("addi_hi", has_imm, 1);
      check("addi_pc", pc_out, 0);
      check("addi_next", mem_addr, 4);
      check("addi_req", mem_req, 1);

      serve(32'h00112223);
      check("sw_bub_prev", op, 17);
      check("sw_rs1", rs1, 2);
      check("sw_rs2", rs2, 1);
      check("sw_rd", rd, 0);
      check("sw_imm", imm, 4);
      check("sw_hi", has_imm, 1);
      check("sw_pc", pc_out, 4);
      step();
      check("one_shot", op, BUB);
      check("hold_rs1", rs1, 2);
      step();

      serve(32'hFE000EE3);
      check("beq_op", op, 4);
      check("beq_imm", imm, 32'hFFFFFFFC);
      check("beq_rd", rd, 0);
      check("beq_pc", pc_out, 8);

      // ADD x3,x1,x2 held back by a full queue
      step();
      mem_ready = 1'b1;
      mem_data  = 32'h002081B3;
      iq_full   = 1'b1;
      step();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("full_op", op, BUB);
         check("full_req", mem_req, 0);
      end
      iq_full = 1'b0;
      step();
      check("add_op", op, 18);
      check("add_rd", rd, 3);
      check("add_rs1", rs1, 1);
      check("add_rs2", rs2, 2);
      check("add_imm", imm, 0);
      check("add_hi", has_imm, 0);
      check("add_pc", pc_out, 12);
      step();
      check("add_once", op, BUB);

      // redirect in WAIT, stale response two cycles later
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check("drain_req", mem_req, 0);
      check("drain_addr", mem_addr, 32'h100);
      step();
      mem_ready = 1'b1;
      mem_data  = 32'h002081B3;
      step();
      mem_ready = 1'b0;
      check("drain_bub", op, BUB);
      check("drain_rereq", mem_req, 1);
      check("drain_new", mem_addr, 32'h100);
      step();
      step();
      check("drain_noiss", op, BUB);

      // now in WAIT at 0x100: SRAI x5,x6,3
      mem_ready = 1'b1;
      mem_data  = 32'h40335293;
      step();
      mem_ready = 1'b0;
      step();
      check("srai_op", op, 25);
      check("srai_imm", imm, 3);
      check("srai_rs1", rs1, 6);
      check("srai_rs2", rs2, 0);
      check("srai_rd", rd, 5);
      check("srai_pc", pc_out, 32'h100);

      serve(32'hFFFFFFFF);
      check("ill_op", op, BUB);
      check("ill_flag", illegal, 1);
      check("ill_next", mem_addr, 32'h108);
      check("ill_pcout", pc_out, 32'h100);

      // redirect beats issue of LUI x7
      step();
      mem_ready = 1'b1;
      mem_data  = 32'h123453B7;
      step();
      mem_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      check("rdi_op", op, BUB);
      check("rdi_addr", mem_addr, 32'h200);
      check("ill_sticky", illegal, 1);

      serve(32'h123453B7);
      check("lui_op", op, 0);
      check("lui_imm", imm, 32'h12345000);
      check("lui_rd", rd, 7);
      check("lui_rs1", rs1, 0);
      check("lui_pc", pc_out, 32'h200);

      // redirect and response together in WAIT
      step();
      mem_ready   = 1'b1;
      mem_data    = 32'h002081B3;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      step();
      mem_ready = 1'b0;
      redirect  = 1'b0;
      check("co_req", mem_req, 1);
      check("co_addr", mem_addr, 32'h300);
      step();
      step();
      check("co_noiss", op, BUB);

      // reset with a response arriving during it
      rst       = 1'b0;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("rst2_ill", illegal, 0);
      check("rst2_addr", mem_addr, 0);
      check("rst2_req", mem_req, 0);
      check("rst2_pcout", pc_out, 0);
      check("rst2_rd", rd, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
